// File: rtl/instr_dispatcher_pkg.sv
// Shared dispatch types: renamed-instruction record, instruction classes and
// the reservation-station class map used by the dispatcher and its queue.
package structures;

   localparam int INFO_XLEN = 32;
   localparam int NUM_RS    = 4;

   localparam logic [1:0] RS_AL = 2'd0;
   localparam logic [1:0] RS_BR = 2'd1;
   localparam logic [1:0] RS_LS = 2'd2;
   localparam logic [1:0] RS_MD = 2'd3;

   typedef enum logic [3:0] {
      UNKNOWN = 4'd0,
      ADD     = 4'd1,
      SUB     = 4'd2,
      BEQ     = 4'd3,
      JAL     = 4'd4,
      LW      = 4'd5,
      SW      = 4'd6,
      MUL     = 4'd7,
      DIV     = 4'd8,
      ILLEGAL = 4'd9
   } instr_name_e;

   typedef enum logic [2:0] {
      AL  = 3'd0,
      BR  = 3'd1,
      JMP = 3'd2,
      LS  = 3'd3,
      MD  = 3'd4,
      XX  = 3'd5
   } instr_type_e;

   typedef struct packed {
      logic tag;
      logic pred_taken;
   } instr_flags_t;

   typedef struct packed {
      instr_name_e           instr_name;
      instr_type_e           instr_type;
      instr_flags_t          flags;
      logic [5:0]            rd;
      logic [5:0]            rs1;
      logic [5:0]            rs2;
      logic [INFO_XLEN-1:0]  imm;
      logic [INFO_XLEN-1:0]  pc;
   } instr_info_t;

   // XX has no station; callers must screen it out before using the class.
   function automatic logic [1:0] class_of(input instr_type_e t);
      case (t)
         BR, JMP: class_of = RS_BR;
         LS:      class_of = RS_LS;
         MD:      class_of = RS_MD;
         default: class_of = RS_AL;
      endcase
   endfunction

endpackage

// File: rtl/instr_dispatcher_queue.sv
// In-order circular instruction queue: 2-wide push, 0..2 pop, flush, and
// (with DISPATCH_TAG_CLEAR_EN) truncation at the first tagged entry.
module dispatch_queue
   import structures::*;
#(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push_i,
   input  instr_info_t     push_info_i [2],
   input  logic            flush_i,
`ifdef DISPATCH_TAG_CLEAR_EN
   input  logic            clear_i,
`endif
   input  logic [1:0]      pop_i,
   output instr_info_t     head_info_o [2],
   output logic [CW-1:0]   count_o,
   output logic            stop_o
);

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   instr_info_t   mem_q [DEPTH];

   logic          clear_active;
   logic          accept;
   logic          wr0, wr1;
   logic [PW-1:0] wr_idx1;
   logic [1:0]    n_push;

   assign stop_o  = (CW'(DEPTH) - count_q) < CW'(2);
   assign count_o = count_q;

   assign head_info_o[0] = mem_q[head_q];
   assign head_info_o[1] = mem_q[head_q + PW'(1)];

`ifdef DISPATCH_TAG_CLEAR_EN
   logic          tag_found;
   logic [PW-1:0] tag_off;

   assign clear_active = clear_i && !flush_i;

   // Offset from head of the oldest tagged entry among the live ones.
   always_comb begin
      tag_found = 1'b0;
      tag_off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!tag_found && (CW'(i) < count_q) && mem_q[head_q + PW'(i)].flags.tag) begin
            tag_found = 1'b1;
            tag_off   = PW'(i);
         end
      end
   end
`else
   assign clear_active = 1'b0;
`endif

   assign accept  = push_i && !stop_o && !flush_i && !clear_active;
   assign wr0     = accept && (push_info_i[0].instr_name != UNKNOWN);
   assign wr1     = accept && (push_info_i[1].instr_name != UNKNOWN);
   assign wr_idx1 = tail_q + PW'(wr0);
   assign n_push  = {1'b0, wr0} + {1'b0, wr1};

   always_comb begin
      head_d  = head_q + PW'(pop_i);
      tail_d  = tail_q + PW'(n_push);
      count_d = count_q + CW'(n_push) - CW'(pop_i);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
`ifdef DISPATCH_TAG_CLEAR_EN
      else if (clear_active && tag_found) begin
         tail_d  = head_q + tag_off;
         count_d = CW'(tag_off) - CW'(pop_i);
      end
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr0) mem_q[tail_q]  <= push_info_i[0];
      if (wr1) mem_q[wr_idx1] <= push_info_i[1];
   end

endmodule

// File: rtl/instr_dispatcher.sv
// Dispatch stage: queues resolver pairs and issues up to two in-order
// instructions per cycle to the four station classes. Optional macro
// DISPATCH_TAG_CLEAR_EN adds the clear_tagged speculation-recovery port.
module instr_dispatcher
   import structures::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  instr_info_t in_info [2],
   output logic        stop_out,
   input  logic        flush,
`ifdef DISPATCH_TAG_CLEAR_EN
   input  logic        clear_tagged,
`endif
   input  logic        rs_ready [NUM_RS],
   output logic        rs_valid [NUM_RS],
   output instr_info_t rs_info  [NUM_RS],
   output logic        bad_type
);

   localparam int CW = $clog2(DEPTH) + 1;

   if (XLEN != INFO_XLEN) begin : g_xlen_check
      $error("instr_dispatcher: XLEN must match structures::INFO_XLEN");
   end

   instr_info_t   head_info [2];
   instr_info_t   slot_a, slot_b;
   logic [CW-1:0] count;
   logic [1:0]    pop;
   logic [1:0]    cls_a, cls_b;
   logic          clear_act;
   logic          a_live, b_live, a_go;

`ifdef DISPATCH_TAG_CLEAR_EN
   assign clear_act = clear_tagged && !flush;
`else
   assign clear_act = 1'b0;
`endif

   dispatch_queue #(.DEPTH(DEPTH)) u_queue (
      .clock       (clock),
      .reset       (reset),
      .push_i      (in_valid),
      .push_info_i (in_info),
      .flush_i     (flush),
`ifdef DISPATCH_TAG_CLEAR_EN
      .clear_i     (clear_tagged),
`endif
      .pop_i       (pop),
      .head_info_o (head_info),
      .count_o     (count),
      .stop_o      (stop_out)
   );

   assign slot_a = head_info[0];
   assign slot_b = head_info[1];
   assign cls_a  = class_of(slot_a.instr_type);
   assign cls_b  = class_of(slot_b.instr_type);

   // Tagged entries are being discarded this cycle, so they must not issue.
   assign a_live = !flush && (count != '0) && !(clear_act && slot_a.flags.tag);
   assign b_live = (count >= CW'(2)) && !(clear_act && slot_b.flags.tag) &&
                   (slot_b.instr_type != XX) && (cls_b != cls_a);

   always_comb begin
      for (int c = 0; c < NUM_RS; c++) begin
         rs_valid[c] = 1'b0;
         rs_info[c]  = '0;
      end
      bad_type = 1'b0;
      pop      = 2'd0;
      a_go     = 1'b0;
      if (a_live) begin
         if (slot_a.instr_type == XX) begin
            bad_type = 1'b1;
            pop      = 2'd1;
         end else begin
            rs_valid[cls_a] = 1'b1;
            rs_info[cls_a]  = slot_a;
            a_go            = rs_ready[cls_a];
         end
      end
      if (a_go) begin
         pop = 2'd1;
         if (b_live) begin
            rs_valid[cls_b] = 1'b1;
            rs_info[cls_b]  = slot_b;
            if (rs_ready[cls_b]) pop = 2'd2;
         end
      end
   end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Bench for instr_dispatcher: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_instr_dispatcher;
   import structures::*;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   instr_info_t in_info [2];
   logic        stop_out;
   logic        flush;
   logic        clear_tagged;
   logic        rs_ready [4];
   logic        rs_valid [4];
   instr_info_t rs_info  [4];
   logic        bad_type;

   int n_checks = 0;
   int n_pass   = 0;

   instr_info_t mq[$];
   logic        exp_valid [4];
   instr_info_t exp_info  [4];
   logic        exp_bad, exp_stop;
   int          exp_pop, tag_k;

   always #5 clock = ~clock;

   instr_dispatcher #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_info      (in_info),
      .stop_out     (stop_out),
      .flush        (flush),
`ifdef DISPATCH_TAG_CLEAR_EN
      .clear_tagged (clear_tagged),
`endif
      .rs_ready     (rs_ready),
      .rs_valid     (rs_valid),
      .rs_info      (rs_info),
      .bad_type     (bad_type)
   );

   function automatic int tb_class(input instr_type_e t);
      case (t)
         BR, JMP: return 1;
         LS:      return 2;
         MD:      return 3;
         default: return 0;
      endcase
   endfunction

   function automatic instr_info_t mk(input instr_name_e n, input instr_type_e t, input logic tag);
      instr_info_t r;
      r = '0;
      r.instr_name = n;
      r.instr_type = t;
      r.flags.tag  = tag;
      r.flags.pred_taken = 1'($urandom);
      r.rd  = 6'($urandom);
      r.rs1 = 6'($urandom);
      r.rs2 = 6'($urandom);
      r.imm = $urandom;
      r.pc  = $urandom;
      return r;
   endfunction

   // Reference: list of queued instructions, oldest first, driven by the issue rules.
   function automatic void model_eval();
      instr_info_t a, b;
      int ca, cb;
      exp_stop = (DEPTH - mq.size()) < 2;
      exp_bad  = 1'b0;
      exp_pop  = 0;
      tag_k    = -1;
      for (int c = 0; c < 4; c++) begin
         exp_valid[c] = 1'b0;
         exp_info[c]  = '0;
      end
      if (clear_tagged && !flush)
         for (int i = 0; i < mq.size(); i++)
            if (tag_k < 0 && mq[i].flags.tag) tag_k = i;
      if (flush || mq.size() == 0 || tag_k == 0) return;
      a  = mq[0];
      ca = tb_class(a.instr_type);
      if (a.instr_type == XX) begin
         exp_bad = 1'b1;
         exp_pop = 1;
         return;
      end
      exp_valid[ca] = 1'b1;
      exp_info[ca]  = a;
      if (!rs_ready[ca]) return;
      exp_pop = 1;
      if (mq.size() < 2 || tag_k == 1) return;
      b = mq[1];
      if (b.instr_type == XX) return;
      cb = tb_class(b.instr_type);
      if (cb == ca) return;
      exp_valid[cb] = 1'b1;
      exp_info[cb]  = b;
      if (rs_ready[cb]) exp_pop = 2;
   endfunction

   task automatic tick();
      bit acc;
      model_eval();
      acc = in_valid && !exp_stop && !flush && !(clear_tagged && !flush);
      @(posedge clock);
      if (flush) mq.delete();
      else begin
         repeat (exp_pop) void'(mq.pop_front());
         if (tag_k >= 0) begin
            while (mq.size() > tag_k - exp_pop) void'(mq.pop_back());
         end else if (acc) begin
            for (int s = 0; s < 2; s++)
               if (in_info[s].instr_name != UNKNOWN) mq.push_back(in_info[s]);
         end
      end
      @(negedge clock);
   endtask

   task automatic idle();
      in_valid     = 1'b0;
      flush        = 1'b0;
      clear_tagged = 1'b0;
   endtask

   task automatic set_ready(input logic r0, input logic r1, input logic r2, input logic r3);
      rs_ready[0] = r0; rs_ready[1] = r1; rs_ready[2] = r2; rs_ready[3] = r3;
   endtask

   task automatic set_pair(input instr_info_t x, input instr_info_t y);
      in_info[0] = x;
      in_info[1] = y;
      in_valid   = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      in_info[0] = '0;
      in_info[1] = '0;
      set_ready(1, 1, 1, 1);
      #12;
      n_checks++; if (stop_out !== 1'b0) $display("FAIL reset_stop: got %b want 0", stop_out); else n_pass++;
      n_checks++; if (bad_type !== 1'b0) $display("FAIL reset_bad: got %b want 0", bad_type); else n_pass++;
      n_checks++; if (dut.u_queue.count_q !== '0) $display("FAIL reset_count: got %0d want 0", dut.u_queue.count_q); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         n_checks++;
         if (rs_valid[c] !== 1'b0 || rs_info[c] !== '0)
            $display("FAIL reset_rs%0d: got v=%b info=%h want v=0 info=0", c, rs_valid[c], rs_info[c]);
         else n_pass++;
      end
      @(negedge clock);
      reset = 1'b1;
      mq.delete();
   endtask

   task automatic test_alu_ls();
      instr_info_t a, b;
      a = mk(ADD, AL, 1'b0);
      b = mk(LW, LS, 1'b0);
      set_ready(1, 1, 1, 1);
      set_pair(a, b);
      #1;
      n_checks++; if (rs_valid[0] !== 1'b0) $display("FAIL alu_ls_bypass: got %b want 0", rs_valid[0]); else n_pass++;
      tick();
      idle();
      #1;
      n_checks++; if (rs_valid[0] !== 1'b1 || rs_info[0] !== a) $display("FAIL alu_ls_al: got v=%b info=%h want v=1 info=%h", rs_valid[0], rs_info[0], a); else n_pass++;
      n_checks++; if (rs_valid[2] !== 1'b1 || rs_info[2] !== b) $display("FAIL alu_ls_ls: got v=%b info=%h want v=1 info=%h", rs_valid[2], rs_info[2], b); else n_pass++;
      n_checks++; if (rs_valid[1] !== 1'b0 || rs_valid[3] !== 1'b0) $display("FAIL alu_ls_other: got %b%b want 00", rs_valid[1], rs_valid[3]); else n_pass++;
      tick();
      n_checks++; if (dut.u_queue.count_q !== '0) $display("FAIL alu_ls_count: got %0d want 0", dut.u_queue.count_q); else n_pass++;
   endtask

   task automatic test_same_class();
      instr_info_t a, b;
      a = mk(ADD, AL, 1'b0);
      b = mk(SUB, AL, 1'b0);
      set_ready(1, 1, 1, 1);
      set_pair(a, b);
      tick();
      idle();
      #1;
      n_checks++; if (rs_valid[0] !== 1'b1 || rs_info[0] !== a) $display("FAIL same_cls_c1: got v=%b info=%h want v=1 info=%h", rs_valid[0], rs_info[0], a); else n_pass++;
      tick();
      n_checks++; if (dut.u_queue.count_q !== 4'd1) $display("FAIL same_cls_cnt1: got %0d want 1", dut.u_queue.count_q); else n_pass++;
      n_checks++; if (rs_valid[0] !== 1'b1 || rs_info[0] !== b) $display("FAIL same_cls_c2: got v=%b info=%h want v=1 info=%h", rs_valid[0], rs_info[0], b); else n_pass++;
      tick();
      n_checks++; if (rs_valid[0] !== 1'b0) $display("FAIL same_cls_done: got %b want 0", rs_valid[0]); else n_pass++;
   endtask

   task automatic test_backpressure();
      set_ready(0, 0, 0, 0);
      for (int p = 0; p < 4; p++) begin
         set_pair(mk(ADD, AL, 1'b0), mk(LW, LS, 1'b0));
         #1;
         n_checks++; if (stop_out !== 1'b0) $display("FAIL bp_stop_pre%0d: got %b want 0", p, stop_out); else n_pass++;
         tick();
      end
      n_checks++; if (dut.u_queue.count_q !== 4'd8) $display("FAIL bp_full_count: got %0d want 8", dut.u_queue.count_q); else n_pass++;
      n_checks++; if (stop_out !== 1'b1) $display("FAIL bp_full_stop: got %b want 1", stop_out); else n_pass++;
      set_pair(mk(SUB, AL, 1'b0), mk(SW, LS, 1'b0));
      tick();
      n_checks++; if (dut.u_queue.count_q !== 4'd8) $display("FAIL bp_fifth: got %0d want 8", dut.u_queue.count_q); else n_pass++;
      set_ready(1, 1, 1, 1);
      tick();
      n_checks++; if (dut.u_queue.count_q !== 4'd6) $display("FAIL bp_full_pop: got %0d want 6", dut.u_queue.count_q); else n_pass++;
      set_ready(0, 0, 0, 0);
      set_pair(mk(ADD, AL, 1'b0), '0);
      tick();
      n_checks++; if (dut.u_queue.count_q !== 4'd7 || stop_out !== 1'b1) $display("FAIL bp_seven: got count=%0d stop=%b want count=7 stop=1", dut.u_queue.count_q, stop_out); else n_pass++;
      set_ready(1, 0, 0, 0);
      set_pair(mk(ADD, AL, 1'b0), mk(LW, LS, 1'b0));
      tick();
      n_checks++; if (dut.u_queue.count_q !== 4'd6) $display("FAIL bp_seven_pop: got %0d want 6", dut.u_queue.count_q); else n_pass++;
      idle();
      flush = 1'b1;
      tick();
      idle();
      n_checks++; if (dut.u_queue.count_q !== '0 || stop_out !== 1'b0) $display("FAIL bp_drain: got count=%0d stop=%b want 0/0", dut.u_queue.count_q, stop_out); else n_pass++;
   endtask

   task automatic test_in_order();
      instr_info_t a, b;
      a = mk(LW, LS, 1'b0);
      b = mk(ADD, AL, 1'b0);
      set_ready(1, 1, 0, 1);
      set_pair(a, b);
      tick();
      idle();
      #1;
      n_checks++; if (rs_valid[2] !== 1'b1 || rs_valid[0] !== 1'b0) $display("FAIL inord_stall1: got ls=%b al=%b want 1/0", rs_valid[2], rs_valid[0]); else n_pass++;
      tick();
      n_checks++; if (rs_valid[0] !== 1'b0 || dut.u_queue.count_q !== 4'd2) $display("FAIL inord_stall2: got al=%b count=%0d want 0/2", rs_valid[0], dut.u_queue.count_q); else n_pass++;
      rs_ready[2] = 1'b1;
      #1;
      n_checks++; if (rs_valid[0] !== 1'b1 || rs_info[0] !== b) $display("FAIL inord_release: got v=%b info=%h want v=1 info=%h", rs_valid[0], rs_info[0], b); else n_pass++;
      tick();
      n_checks++; if (dut.u_queue.count_q !== '0) $display("FAIL inord_count: got %0d want 0", dut.u_queue.count_q); else n_pass++;
   endtask

   task automatic test_flush();
      set_ready(0, 0, 0, 0);
      set_pair(mk(ADD, AL, 1'b0), mk(MUL, MD, 1'b0));
      tick();
      set_pair(mk(BEQ, BR, 1'b0), mk(SW, LS, 1'b0));
      flush = 1'b1;
      #1;
      for (int c = 0; c < 4; c++) begin
         n_checks++; if (rs_valid[c] !== 1'b0) $display("FAIL flush_rs%0d: got %b want 0", c, rs_valid[c]); else n_pass++;
      end
      tick();
      idle();
      #1;
      n_checks++; if (dut.u_queue.count_q !== '0) $display("FAIL flush_count: got %0d want 0", dut.u_queue.count_q); else n_pass++;
      n_checks++; if (rs_valid[0] !== 1'b0 || rs_valid[1] !== 1'b0) $display("FAIL flush_after: got %b%b want 00", rs_valid[0], rs_valid[1]); else n_pass++;
   endtask

   task automatic test_bad_type();
      instr_info_t b;
      b = mk(ADD, AL, 1'b0);
      set_ready(1, 1, 1, 1);
      set_pair(mk(ILLEGAL, XX, 1'b0), b);
      tick();
      idle();
      #1;
      n_checks++; if (bad_type !== 1'b1 || rs_valid[0] !== 1'b0) $display("FAIL badtype_drop: got bad=%b al=%b want 1/0", bad_type, rs_valid[0]); else n_pass++;
      tick();
      n_checks++; if (bad_type !== 1'b0 || rs_valid[0] !== 1'b1 || rs_info[0] !== b) $display("FAIL badtype_next: got bad=%b al=%b info=%h want 0/1 %h", bad_type, rs_valid[0], rs_info[0], b); else n_pass++;
      tick();
      n_checks++; if (dut.u_queue.count_q !== '0) $display("FAIL badtype_count: got %0d want 0", dut.u_queue.count_q); else n_pass++;
   endtask

   task automatic test_async_reset();
      set_ready(0, 0, 0, 0);
      set_pair(mk(ADD, AL, 1'b0), mk(LW, LS, 1'b0));
      tick();
      set_pair(mk(MUL, MD, 1'b0), mk(JAL, JMP, 1'b0));
      tick();
      idle();
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (dut.u_queue.count_q !== '0 || stop_out !== 1'b0) $display("FAIL areset_state: got count=%0d stop=%b want 0/0", dut.u_queue.count_q, stop_out); else n_pass++;
      n_checks++; if (rs_valid[0] !== 1'b0 || rs_info[0] !== '0) $display("FAIL areset_rs: got v=%b info=%h want 0/0", rs_valid[0], rs_info[0]); else n_pass++;
      mq.delete();
      @(negedge clock);
      reset = 1'b1;
   endtask

`ifdef DISPATCH_TAG_CLEAR_EN
   task automatic test_tag_clear();
      instr_info_t u0, u1;
      u0 = mk(ADD, AL, 1'b0);
      u1 = mk(LW, LS, 1'b0);
      set_ready(0, 0, 0, 0);
      set_pair(u0, u1);
      tick();
      set_pair(mk(MUL, MD, 1'b1), mk(BEQ, BR, 1'b1));
      tick();
      idle();
      clear_tagged = 1'b1;
      #1;
      n_checks++; if (rs_valid[0] !== 1'b1 || rs_valid[1] !== 1'b0 || rs_valid[3] !== 1'b0) $display("FAIL tag_offer: got al=%b br=%b md=%b want 1/0/0", rs_valid[0], rs_valid[1], rs_valid[3]); else n_pass++;
      tick();
      clear_tagged = 1'b0;
      n_checks++; if (dut.u_queue.count_q !== 4'd2) $display("FAIL tag_count: got %0d want 2", dut.u_queue.count_q); else n_pass++;
      set_ready(1, 1, 1, 1);
      #1;
      n_checks++; if (rs_info[0] !== u0 || rs_info[2] !== u1 || rs_valid[1] !== 1'b0 || rs_valid[3] !== 1'b0) $display("FAIL tag_issue: got al=%h ls=%h br=%b md=%b", rs_info[0], rs_info[2], rs_valid[1], rs_valid[3]); else n_pass++;
      tick();
      n_checks++; if (dut.u_queue.count_q !== '0) $display("FAIL tag_drain: got %0d want 0", dut.u_queue.count_q); else n_pass++;
   endtask
`endif

   task automatic test_random();
      instr_type_e t;
      for (int cyc = 0; cyc < 600; cyc++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         for (int s = 0; s < 2; s++) begin
            t = ($urandom_range(0, 19) == 0) ? XX : instr_type_e'($urandom_range(0, 4));
            in_info[s] = mk(instr_name_e'($urandom_range(0, 9)), t, 1'($urandom));
         end
         for (int c = 0; c < 4; c++)
            rs_ready[c] = ((cyc / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 39) == 0);
`ifdef DISPATCH_TAG_CLEAR_EN
         clear_tagged = ($urandom_range(0, 14) == 0);
`endif
         #1;
         model_eval();
         n_checks++; if (stop_out !== exp_stop) $display("FAIL rnd_stop cyc %0d: got %b want %b", cyc, stop_out, exp_stop); else n_pass++;
         n_checks++; if (bad_type !== exp_bad) $display("FAIL rnd_bad cyc %0d: got %b want %b", cyc, bad_type, exp_bad); else n_pass++;
         n_checks++; if (int'(dut.u_queue.count_q) != mq.size()) $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, dut.u_queue.count_q, mq.size()); else n_pass++;
         for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (rs_valid[c] !== exp_valid[c] || rs_info[c] !== exp_info[c])
               $display("FAIL rnd_rs%0d cyc %0d: got v=%b info=%h want v=%b info=%h", c, cyc, rs_valid[c], rs_info[c], exp_valid[c], exp_info[c]);
            else n_pass++;
         end
         tick();
      end
      idle();
      flush = 1'b1;
      tick();
      idle();
   endtask

   initial begin
      test_reset();
      test_alu_ls();
      test_same_class();
      test_backpressure();
      test_in_order();
      test_flush();
      test_bad_type();
      test_async_reset();
`ifdef DISPATCH_TAG_CLEAR_EN
      test_tag_clear();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
